// File: rtl/il_cmd_ctrl.sv
// il_cmd_ctrl: valid/ready command sequencer driving clk_en, breakpoint and clk_step of the interruption logic.
module il_cmd_ctrl #(
  parameter logic [31:0] BP_RESET = 32'hFFFF_FFFF,
  parameter int          STEP_HI  = 2,
  parameter int          STEP_LO  = 2
) (
  input  logic        sys_clk,
  input  logic        sys_reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  input  logic        break_in,
  output logic        clk_en,
  output logic [31:0] breakpoint,
  output logic        clk_step,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic        busy
);
  localparam int PMAX = (STEP_HI > STEP_LO) ? STEP_HI : STEP_LO;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam logic [2:0] OP_SET_BP = 3'd1, OP_RUN = 3'd2, OP_HALT = 3'd3, OP_STEP = 3'd4;
  localparam logic [1:0] RSP_OK = 2'd0, RSP_BUSY = 2'd1, RSP_BAD = 2'd2, RSP_BRK = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HI, S_LO} state_t;
  state_t      state_q, state_d;
  logic        clk_en_q, clk_en_d, clk_step_q, clk_step_d, rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic [31:0] bp_q, bp_d, cnt_q, cnt_d;
  logic [PW-1:0] ph_q, ph_d;
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q      <= S_IDLE;
      clk_en_q     <= 1'b0;
      clk_step_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= RSP_OK;
      bp_q         <= BP_RESET;
      cnt_q        <= '0;
      ph_q         <= '0;
    end else begin
      state_q      <= state_d;
      clk_en_q     <= clk_en_d;
      clk_step_q   <= clk_step_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      bp_q         <= bp_d;
      cnt_q        <= cnt_d;
      ph_q         <= ph_d;
    end
  end
  always_comb begin
    state_d      = state_q;
    clk_en_d     = clk_en_q;
    clk_step_d   = clk_step_q;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    bp_d         = bp_q;
    cnt_d        = cnt_q;
    ph_d         = ph_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        rsp_valid_d  = 1'b1;
        rsp_status_d = (cmd_op > OP_STEP) ? RSP_BAD : RSP_OK;
        case (cmd_op)
          OP_SET_BP: bp_d = cmd_arg;
          OP_HALT:   clk_en_d = 1'b0;
          OP_RUN: begin
            clk_en_d    = 1'b1;
            state_d     = S_RUN;
            rsp_valid_d = 1'b0;
          end
          OP_STEP: begin
            cnt_d       = (cmd_arg == 32'd0) ? 32'd1 : cmd_arg;
            clk_step_d  = 1'b1;
            ph_d        = '0;
            state_d     = S_HI;
            rsp_valid_d = 1'b0;
          end
          default: ;
        endcase
      end
      // a break in the same cycle as a command swallows the command
      S_RUN: if (break_in || cmd_valid) begin
        rsp_valid_d  = 1'b1;
        rsp_status_d = break_in ? RSP_BRK : (cmd_op == OP_HALT) ? RSP_OK : (cmd_op > OP_STEP) ? RSP_BAD : RSP_BUSY;
        if (break_in || cmd_op == OP_HALT) begin
          clk_en_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_HI: if (ph_q == PW'(STEP_HI - 1)) begin
        clk_step_d = 1'b0;
        ph_d       = '0;
        state_d    = S_LO;
      end else ph_d = ph_q + 1'b1;
      S_LO: if (ph_q == PW'(STEP_LO - 1)) begin
        cnt_d      = cnt_q - 32'd1;
        ph_d       = '0;
        clk_step_d = (cnt_q != 32'd1);
        state_d    = (cnt_q == 32'd1) ? S_IDLE : S_HI;
        if (cnt_q == 32'd1) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = RSP_OK;
        end
      end else ph_d = ph_q + 1'b1;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    cmd_ready  = (state_q == S_IDLE) || (state_q == S_RUN);
    busy       = (state_q != S_IDLE);
    clk_en     = clk_en_q;
    clk_step   = clk_step_q;
    breakpoint = bp_q;
    rsp_valid  = rsp_valid_q;
    rsp_status = rsp_status_q;
  end
endmodule

// File: tb/tb_il_cmd_ctrl.sv
// tb_il_cmd_ctrl: directed checks of the command sequencer with hand-computed expectations.
module tb_il_cmd_ctrl;
  logic        sys_clk = 1'b0, sys_reset_n = 1'b0, cmd_valid = 1'b0, break_in = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [31:0] cmd_arg = '0;
  logic        cmd_ready, clk_en, clk_step, rsp_valid, busy;
  logic [31:0] breakpoint;
  logic [1:0]  rsp_status;
  int n_chk = 0, n_fail = 0;
  always #5 sys_clk = ~sys_clk;
  il_cmd_ctrl dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .break_in(break_in), .clk_en(clk_en),
    .breakpoint(breakpoint), .clk_step(clk_step), .rsp_valid(rsp_valid),
    .rsp_status(rsp_status), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // called at a negedge; returns at the negedge of the cycle after acceptance
  task automatic send(input logic [2:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge sys_clk);
    #1 cmd_valid = 1'b0;
    @(negedge sys_clk);
  endtask
  task automatic step_window(input string tag, input int n, input logic [31:0] exp_pat);
    logic [31:0] pat = '0;
    logic rdy = 1'b0, rv = 1'b0, en = 1'b0;
    for (int i = 0; i < n; i++) begin
      pat = {pat[30:0], clk_step};
      rdy |= cmd_ready;
      rv  |= rsp_valid;
      en  |= clk_en;
      @(negedge sys_clk);
    end
    check({tag, " step pattern"}, pat, exp_pat);
    check({tag, " ready during"}, {31'd0, rdy}, 32'd0);
    check({tag, " early rsp"}, {31'd0, rv}, 32'd0);
    check({tag, " clk_en during"}, {31'd0, en}, 32'd0);
    check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, " rsp_status"}, {30'd0, rsp_status}, 32'd0);
    check({tag, " ready after"}, {31'd0, cmd_ready}, 32'd1);
  endtask
  initial begin
    int hi = 0;
    #12;
    check("rst clk_en", {31'd0, clk_en}, 32'd0);
    check("rst clk_step", {31'd0, clk_step}, 32'd0);
    check("rst bp", breakpoint, 32'hFFFF_FFFF);
    check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst ready", {31'd0, cmd_ready}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    @(negedge sys_clk) sys_reset_n = 1'b1;
    @(negedge sys_clk);
    send(3'd1, 32'd10);
    check("setbp rsp", {31'd0, rsp_valid}, 32'd1);
    check("setbp status", {30'd0, rsp_status}, 32'd0);
    check("setbp bp", breakpoint, 32'd10);
    send(3'd2, 32'd0);
    check("run no rsp", {31'd0, rsp_valid}, 32'd0);
    check("run busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      hi += (clk_en && !rsp_valid) ? 1 : 0;
      if (i < 9) @(negedge sys_clk);
    end
    check("run enabled cycles", hi, 32'd10);
    break_in = 1'b1;
    @(negedge sys_clk);
    break_in = 1'b0;
    check("brk rsp", {31'd0, rsp_valid}, 32'd1);
    check("brk status", {30'd0, rsp_status}, 32'd3);
    check("brk clk_en", {31'd0, clk_en}, 32'd0);
    check("brk idle", {31'd0, busy}, 32'd0);
    @(negedge sys_clk);
    check("brk one-shot", {31'd0, rsp_valid}, 32'd0);
    send(3'd4, 32'd3);
    step_window("step3", 12, 32'hCCC);
    send(3'd4, 32'd0);
    step_window("step0", 4, 32'hC);
    send(3'd2, 32'd0);
    check("run2 clk_en", {31'd0, clk_en}, 32'd1);
    send(3'd1, 32'd5);
    check("busy rsp", {31'd0, rsp_valid}, 32'd1);
    check("busy status", {30'd0, rsp_status}, 32'd1);
    check("busy bp", breakpoint, 32'd10);
    send(3'd7, 32'd0);
    check("run badop status", {30'd0, rsp_status}, 32'd2);
    check("run badop busy", {31'd0, busy}, 32'd1);
    send(3'd3, 32'd0);
    check("halt rsp", {31'd0, rsp_valid}, 32'd1);
    check("halt status", {30'd0, rsp_status}, 32'd0);
    check("halt clk_en", {31'd0, clk_en}, 32'd0);
    check("halt idle", {31'd0, busy}, 32'd0);
    send(3'd6, 32'd123);
    check("badop rsp", {31'd0, rsp_valid}, 32'd1);
    check("badop status", {30'd0, rsp_status}, 32'd2);
    check("badop clk_en", {31'd0, clk_en}, 32'd0);
    check("badop bp", breakpoint, 32'd10);
    check("badop clk_step", {31'd0, clk_step}, 32'd0);
    check("badop idle", {31'd0, busy}, 32'd0);
    break_in = 1'b1;
    send(3'd2, 32'd0);
    check("prebrk clk_en", {31'd0, clk_en}, 32'd1);
    check("prebrk no rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge sys_clk);
    break_in = 1'b0;
    check("prebrk rsp", {31'd0, rsp_valid}, 32'd1);
    check("prebrk status", {30'd0, rsp_status}, 32'd3);
    check("prebrk clk_en off", {31'd0, clk_en}, 32'd0);
    @(negedge sys_clk);
    send(3'd2, 32'd0);
    break_in = 1'b1;
    send(3'd1, 32'd99);
    break_in = 1'b0;
    check("brk+cmd status", {30'd0, rsp_status}, 32'd3);
    check("brk+cmd bp", breakpoint, 32'd10);
    check("brk+cmd clk_en", {31'd0, clk_en}, 32'd0);
    @(negedge sys_clk);
    check("brk+cmd single rsp", {31'd0, rsp_valid}, 32'd0);
    send(3'd4, 32'd5);
    check("rstmid clk_step before", {31'd0, clk_step}, 32'd1);
    #2 sys_reset_n = 1'b0;
    #1;
    check("rstmid clk_step", {31'd0, clk_step}, 32'd0);
    check("rstmid bp", breakpoint, 32'hFFFF_FFFF);
    check("rstmid rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge sys_clk) sys_reset_n = 1'b1;
    @(negedge sys_clk);
    check("rstmid ready", {31'd0, cmd_ready}, 32'd1);
    check("rstmid busy", {31'd0, busy}, 32'd0);
    hi = 0;
    repeat (6) begin
      hi += (rsp_valid || clk_step) ? 1 : 0;
      @(negedge sys_clk);
    end
    check("rstmid quiet", hi, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/il_cmd_ctrl.md
# il_cmd_ctrl

Command sequencer that drives the interruption logic's control inputs (`clk_en`, `breakpoint`, `clk_step`) from a valid/ready command stream, in place of manual VIO control. It sits directly upstream of the interruption logic in the `sys_clk` domain. It runs the task clock to a breakpoint, halts it, or issues N single steps, and it reports completion on a one-cycle response strobe.

## Interface
- `BP_RESET`, 32'hFFFF_FFFF, breakpoint value loaded at reset.
- `STEP_HI`, 2, cycles `clk_step` is held high per step (≥1).
- `STEP_LO`, 2, cycles `clk_step` is held low after each step (≥1).
- `sys_clk`  in  1  system clock; the only clock.
- `sys_reset_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command valid.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready` at a rising edge.
- `cmd_op`  in  3  0 NOP, 1 SET_BP, 2 RUN, 3 HALT, 4 STEP; 5–7 illegal.
- `cmd_arg`  in  32  SET_BP: breakpoint value; STEP: step count; ignored otherwise.
- `break_in`  in  1  `break` from interruption logic.
- `clk_en`  out  1  to interruption logic.
- `breakpoint`  out  32  to interruption logic.
- `clk_step`  out  1  to interruption logic; it steps on the rising edge.
- `rsp_valid`  out  1  one-cycle completion strobe.
- `rsp_status`  out  2  0 OK, 1 BUSY, 2 BAD_OP, 3 BREAK_HIT.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RUN, STEP_HI, STEP_LO.
- Reset (async, immediate): state IDLE, `clk_en`=0, `clk_step`=0, `breakpoint`=BP_RESET, `rsp_valid`=0, `rsp_status`=0, step counter 0. `cmd_ready`=1 and `busy`=0 once state is IDLE.
- `cmd_ready`=1 in IDLE and RUN; 0 in STEP_HI and STEP_LO.
- IDLE, accepted command:
  - NOP → rsp OK.
  - SET_BP → `breakpoint`←`cmd_arg`, rsp OK.
  - RUN → `clk_en`←1, go RUN, no rsp yet.
  - HALT → `clk_en`←0, rsp OK.
  - STEP → counter←(`cmd_arg`==0 ? 1 : `cmd_arg`), `clk_step`←1, go STEP_HI, no rsp yet.
  - op 5–7 → rsp BAD_OP, no state change.
- RUN:
  - `break_in`=1 → `clk_en`←0, go IDLE, rsp BREAK_HIT.
  - Accepted HALT → `clk_en`←0, go IDLE, rsp OK.
  - Accepted NOP/SET_BP/RUN/STEP → rsp BUSY, no effect.
  - Accepted op 5–7 → rsp BAD_OP.
  - Break and accepted command in the same cycle: break wins, rsp BREAK_HIT, and the command is consumed with no separate response.
- STEP_HI: `clk_step`=1 for STEP_HI cycles, then `clk_step`←0 and go STEP_LO.
- STEP_LO: `clk_step`=0 for STEP_LO cycles, then counter decrements.
  - Counter reaches 0 → go IDLE, rsp OK.
  - Otherwise → `clk_step`←1, go STEP_HI.
- `clk_en`=0 throughout stepping. `break_in` is ignored outside RUN.
- RUN entered with `break_in` already 1: exit to IDLE on the next cycle with BREAK_HIT.
- Counter is 32-bit unsigned; 32'hFFFF_FFFF steps are legal, with no wrap.
- Reset mid-operation: everything returns to reset values and no response is issued for the interrupted command.

## Timing
- All outputs are registered except `cmd_ready` and `busy`, which decode registered state only (no input-to-output combinational path).
- Command accepted at edge N:
  - `clk_en`, `breakpoint` and `clk_step` change after edge N.
  - Immediate responses: `rsp_valid`=1 during cycle N+1 only.
- STEP of k steps accepted at edge N:
  - `clk_step` first rises after N.
  - Period is STEP_HI+STEP_LO cycles.
  - `rsp_valid` follows the last low phase: high k·(STEP_HI+STEP_LO) cycles after N, for one cycle.
- `break_in` sampled high at edge M in RUN: `clk_en`=0 and `rsp_valid`=1 after M.
- Back-to-back commands: a new command can be accepted in the cycle where `rsp_valid` is high.

## Test plan
- SET_BP arg=10, then RUN; model asserts `break_in` after counting 10 enabled cycles → `breakpoint`=10, two OK/none responses as specified, `clk_en` high until break, then rsp BREAK_HIT and `clk_en`=0.
- STEP arg=3 with defaults → exactly 3 `clk_step` rising edges, each high 2 and low 2 cycles; rsp OK 12 cycles after accept; `cmd_ready`=0 throughout.
- STEP arg=0 → one step, rsp OK after 4 cycles.
- RUN, then SET_BP 5 → rsp BUSY and `breakpoint` unchanged; then HALT → rsp OK, `clk_en`=0, state IDLE.
- op=6 in IDLE → rsp BAD_OP; `clk_en`, `breakpoint` and `clk_step` unchanged.
- Assert `sys_reset_n`=0 mid STEP_HI with 5 steps remaining → `clk_step`=0 and `breakpoint`=FFFF_FFFF immediately, no rsp; after release, `cmd_ready`=1.
